// File: rtl/dm_store_unit.sv
// dm_store_unit: store-side lane steering and write buffer for the MEM stage.
// Accepts SW/SH/SB requests, places the data on the correct byte lanes and
// builds the byte enables. Aligned word writes queue in a DEPTH-entry circular
// buffer, which drains to data memory over a mem_req/mem_ack handshake.
// Optional feature macro: DMSTORE_ALIGN_CHECK_EN enables rejection of
// misaligned SW/SH stores, reported by a one-cycle st_err pulse.
module dm_store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  input  logic [2:0]  st_sel,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_err,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  localparam logic [2:0] SEL_SW = 3'd1;
  localparam logic [2:0] SEL_SH = 3'd2;
  localparam logic [2:0] SEL_SB = 3'd3;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_is_store;
  logic            w_misaligned;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  entry_t          w_head;

  assign w_is_store = (st_sel == SEL_SW) || (st_sel == SEL_SH) || (st_sel == SEL_SB);
  assign w_empty    = (r_count == '0);
  assign st_ready   = (r_count < CNT_FULL);
  assign busy       = !w_empty;
  assign mem_req    = !w_empty;
  assign w_push     = st_valid && st_ready && w_is_store && !w_misaligned;
  assign w_pop      = mem_req && mem_ack;

`ifdef DMSTORE_ALIGN_CHECK_EN
  logic r_err;

  assign w_misaligned = ((st_sel == SEL_SW) && (st_addr[1:0] != 2'b00)) ||
                        ((st_sel == SEL_SH) && st_addr[0]);
  assign st_err       = r_err;

  // Registered error pulse: high for the cycle after a rejected misaligned store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= st_valid && st_ready && w_is_store && w_misaligned;
    end
  end
`else
  assign w_misaligned = 1'b0;
  assign st_err       = 1'b0;
`endif

  // Lane steering: byte enables and replicated write data for the request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (st_sel)
      SEL_SW: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
      end
      SEL_SH: begin
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
      end
      SEL_SB: begin
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Buffer storage write port.
  // NOTE: the entry array has no reset; an entry is only visible once count
  // covers it, and the empty-case output gating hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{word: st_addr[31:2], data: w_wdata, be: w_be};
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry drives the memory port; all fields read zero when empty.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (!w_empty) begin
      mem_addr  = {w_head.word, 2'b00};
      mem_wdata = w_head.data;
      mem_be    = w_head.be;
    end
  end

endmodule
